// File: rtl/sa_result_drain.sv
// Systolic-array result drain: captures one result frame and streams it
// out as fixed-width beats over valid/ready, with optional per-element ReLU.
module sa_result_drain #(
  parameter int X_R        = 2,
  parameter int COLS       = 64,
  parameter int BEAT_ELEMS = 4
) (
  input  logic                                I_CLK,
  input  logic                                I_RST,
  input  logic                                I_IN_VLD,
  input  logic [X_R*COLS*16-1:0]              I_IN,
  input  logic                                I_RELU_EN,
  input  logic                                I_OVF_CLR,
  output logic                                O_BUSY,
  output logic                                O_OVF,
  output logic                                O_TVALID,
  input  logic                                I_TREADY,
  output logic [BEAT_ELEMS*16-1:0]            O_TDATA,
  output logic [((X_R>1)?$clog2(X_R):1)-1:0]  O_ROW,
  output logic                                O_TLAST
);

  localparam int FW  = X_R*COLS*16;
  localparam int BW  = BEAT_ELEMS*16;
  localparam int NB  = X_R*COLS/BEAT_ELEMS;
  localparam int BPR = COLS/BEAT_ELEMS;
  localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW  = (X_R > 1) ? $clog2(X_R) : 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   buf_q, buf_d;
  logic            relu_q, relu_d;
  logic            ovf_q, ovf_d;

  logic            valid;
  logic            last;
  logic            hs;
  logic [BW-1:0]   raw_beat;
  logic [BW-1:0]   act_beat;

  assign valid    = (state_q == SEND);
  assign last     = (cnt_q == CW'(NB-1));
  assign hs       = valid & I_TREADY;
  assign raw_beat = buf_q[cnt_q*BW +: BW];

  always_comb begin
    act_beat = raw_beat;
    for (int k = 0; k < BEAT_ELEMS; k++) begin
      if (relu_q && raw_beat[k*16+15]) begin
        act_beat[k*16 +: 16] = 16'h0000;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    relu_d  = relu_q;
    ovf_d   = ovf_q;
    if (I_OVF_CLR) begin
      ovf_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (I_IN_VLD) begin
          buf_d   = I_IN;
          relu_d  = I_RELU_EN;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs && last) begin
          cnt_d = '0;
          if (I_IN_VLD) begin
            // back-to-back capture keeps the stream gapless
            buf_d  = I_IN;
            relu_d = I_RELU_EN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (hs) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (I_IN_VLD) begin
            ovf_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      relu_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      relu_q  <= relu_d;
      ovf_q   <= ovf_d;
    end
  end

  assign O_BUSY   = valid;
  assign O_TVALID = valid;
  assign O_OVF    = ovf_q;
  assign O_TDATA  = valid ? act_beat : '0;
  assign O_ROW    = valid ? RW'(cnt_q / BPR) : '0;
  assign O_TLAST  = valid & last;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain with a queue-of-beats reference model
// checked every cycle plus literal expectations from hand calculation.
module tb_sa_result_drain;

  localparam int X_R  = 2;
  localparam int COLS = 64;
  localparam int BE   = 4;
  localparam int FW   = X_R*COLS*16;
  localparam int BW   = BE*16;
  localparam int NB   = X_R*COLS/BE;

  logic          I_CLK = 0;
  logic          I_RST = 1;
  logic          I_IN_VLD = 0;
  logic [FW-1:0] I_IN = '0;
  logic          I_RELU_EN = 0;
  logic          I_OVF_CLR = 0;
  logic          I_TREADY = 0;
  logic          O_BUSY, O_OVF, O_TVALID, O_TLAST;
  logic [BW-1:0] O_TDATA;
  logic [0:0]    O_ROW;

  int vectors = 0;
  int miscompares = 0;

  sa_result_drain #(.X_R(X_R), .COLS(COLS), .BEAT_ELEMS(BE)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_IN_VLD(I_IN_VLD), .I_IN(I_IN),
    .I_RELU_EN(I_RELU_EN), .I_OVF_CLR(I_OVF_CLR), .O_BUSY(O_BUSY),
    .O_OVF(O_OVF), .O_TVALID(O_TVALID), .I_TREADY(I_TREADY),
    .O_TDATA(O_TDATA), .O_ROW(O_ROW), .O_TLAST(O_TLAST)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [0:0]    row;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  logic  m_ovf = 0;
  bit    m_hs, m_acc;

  function automatic beat_t mk_beat(input logic [FW-1:0] f,
                                    input logic relu, input int b);
    beat_t t;
    logic [15:0] e;
    t.data = '0;
    for (int k = 0; k < BE; k++) begin
      e = f[(b*BE+k)*16 +: 16];
      if (relu && e[15]) e = 16'h0000;
      t.data[k*16 +: 16] = e;
    end
    t.row  = 1'((b*BE)/COLS);
    t.last = (b == NB-1);
    return t;
  endfunction

  function automatic logic [FW-1:0] ramp(input int off);
    logic [FW-1:0] r;
    r = '0;
    for (int i = 0; i < X_R*COLS; i++) r[i*16 +: 16] = 16'(i+off);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: the frame is a queue of pending beats
  always @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      exp_q.delete();
      m_ovf = 0;
    end else begin
      m_hs  = (exp_q.size() > 0) && I_TREADY;
      m_acc = I_IN_VLD && (exp_q.size() == 0 ||
                           (exp_q.size() == 1 && m_hs));
      if (m_hs) void'(exp_q.pop_front());
      if (m_acc)
        for (int b = 0; b < NB; b++)
          exp_q.push_back(mk_beat(I_IN, I_RELU_EN, b));
      if (I_IN_VLD && !m_acc) m_ovf = 1;
      else if (I_OVF_CLR) m_ovf = 0;
    end
  end

  always @(negedge I_CLK) begin
    if (!I_RST) begin
      chk("m_tvalid", O_TVALID, exp_q.size() > 0);
      chk("m_busy", O_BUSY, exp_q.size() > 0);
      chk("m_ovf", O_OVF, m_ovf);
      if (exp_q.size() > 0) begin
        chk("m_tdata", O_TDATA, exp_q[0].data);
        chk("m_row", O_ROW, exp_q[0].row);
        chk("m_tlast", O_TLAST, exp_q[0].last);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge I_CLK);
      #1;
    end
  endtask

  task automatic drive_frame(input logic [FW-1:0] f, input logic relu);
    I_IN = f;
    I_RELU_EN = relu;
    I_IN_VLD = 1;
    step(1);
    I_IN_VLD = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (O_BUSY && n < 200) begin
      step(1);
      n++;
    end
    chk("drain_timeout", O_BUSY, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, O_BUSY, 0);
    chk({tag, "_ovf"}, O_OVF, 0);
    chk({tag, "_tvalid"}, O_TVALID, 0);
    chk({tag, "_tdata"}, O_TDATA, 0);
    chk({tag, "_row"}, O_ROW, 0);
    chk({tag, "_tlast"}, O_TLAST, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] f;
    logic [BW-1:0] held;
    bit            stalled;
    int            hs;

    #2 chk_zero("rst");
    step(1);
    I_RST = 0;
    for (int i = 0; i < 6; i++) begin
      I_TREADY = ~I_TREADY;
      step(1);
      chk("idle_tvalid", O_TVALID, 0);
    end

    I_TREADY = 1;
    drive_frame(ramp(0), 0);
    chk("b0_data", O_TDATA, 64'h0003_0002_0001_0000);
    chk("b0_row", O_ROW, 0);
    step(16);
    chk("b16_data", O_TDATA, 64'h0043_0042_0041_0040);
    chk("b16_row", O_ROW, 1);
    step(15);
    chk("b31_data", O_TDATA, 64'h007F_007E_007D_007C);
    chk("b31_last", O_TLAST, 1);
    step(1);
    chk("end_busy", O_BUSY, 0);
    chk("end_tvalid", O_TVALID, 0);

    drive_frame(ramp(16'h200), 0);
    hs = 0;
    stalled = 0;
    held = '0;
    for (int n = 0; n < 400 && O_BUSY; n++) begin
      I_TREADY = 1'($urandom_range(0, 1));
      @(negedge I_CLK);
      if (stalled) chk("stall_data", O_TDATA, held);
      if (O_TVALID && I_TREADY) hs++;
      stalled = O_TVALID && !I_TREADY;
      held = O_TDATA;
      @(posedge I_CLK);
      #1;
    end
    chk("bp_busy", O_BUSY, 0);
    chk("bp_handshakes", hs, NB);
    I_TREADY = 1;

    f = '0;
    f[15:0]  = 16'hE000;
    f[31:16] = 16'h2000;
    f[47:32] = 16'h8000;
    f[63:48] = 16'h1000;
    drive_frame(f, 1);
    chk("relu_on", O_TDATA, 64'h1000_0000_2000_0000);
    wait_idle();
    drive_frame(f, 0);
    chk("relu_off", O_TDATA, 64'h1000_8000_2000_E000);
    wait_idle();

    drive_frame(ramp(16'h300), 0);
    step(5);
    I_IN = ramp(16'h700);
    I_IN_VLD = 1;
    step(1);
    I_IN_VLD = 0;
    chk("ovf_set", O_OVF, 1);
    chk("ovf_b6", O_TDATA, 64'h031B_031A_0319_0318);
    I_OVF_CLR = 1;
    step(1);
    I_OVF_CLR = 0;
    chk("ovf_clr", O_OVF, 0);
    step(1);
    I_IN_VLD = 1;
    I_OVF_CLR = 1;
    step(1);
    I_IN_VLD = 0;
    chk("ovf_setwins", O_OVF, 1);
    step(1);
    I_OVF_CLR = 0;
    chk("ovf_clr2", O_OVF, 0);
    step(21);
    chk("b2b_last", O_TLAST, 1);
    drive_frame(ramp(16'h400), 0);
    chk("b2b_tvalid", O_TVALID, 1);
    chk("b2b_data", O_TDATA, 64'h0403_0402_0401_0400);
    chk("b2b_tlast", O_TLAST, 0);
    chk("b2b_ovf", O_OVF, 0);
    wait_idle();

    drive_frame(ramp(16'h500), 0);
    step(10);
    chk("b10_data", O_TDATA, 64'h052B_052A_0529_0528);
    #2 I_RST = 1;
    #1 chk_zero("midrst");
    step(1);
    I_RST = 0;
    chk("postrst_tvalid", O_TVALID, 0);
    drive_frame(ramp(16'h600), 0);
    chk("restart_data", O_TDATA, 64'h0603_0602_0601_0600);
    chk("restart_row", O_ROW, 0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
